// File: rtl/alu_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmp_pkg
// Description : Shared types and constants for the serial magnitude
//               comparator: FSM state enum, one-hot result encoding
//               {equal, greater, lesser} and the digit-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    // Result encoding, bit order {equal, greater, lesser}
    localparam logic [2:0] c_EQ = 3'b100;
    localparam logic [2:0] c_GT = 3'b010;
    localparam logic [2:0] c_LT = 3'b001;

    // Number of DIGIT-bit digits in a WIDTH-bit operand
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

endpackage : alu_cmp_pkg
`default_nettype wire

// File: rtl/digit_compare.sv
`default_nettype none
// ============================================================================
// Module      : digit_compare
// Description : Combinational DIGIT-bit magnitude compare. With sign_flip
//               set, the MSB of both digits is inverted first, which turns
//               an unsigned compare into a two's-complement compare of the
//               top digit.
// Ports       : a, b      - digits to compare
//               sign_flip - invert MSB of both digits before comparing
//               gt/lt/eq  - a > b, a < b, a == b (after optional flip)
// Revision    : 1.0 - initial release
// ============================================================================
module digit_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             sign_flip,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    logic [DIGIT-1:0] w_flip;
    logic [DIGIT-1:0] w_a;
    logic [DIGIT-1:0] w_b;

    assign w_flip = DIGIT'(sign_flip) << (DIGIT - 1);
    assign w_a    = a ^ w_flip;
    assign w_b    = b ^ w_flip;

    assign gt = (w_a > w_b);
    assign lt = (w_a < w_b);
    assign eq = (w_a == w_b);

endmodule : digit_compare
`default_nettype wire

// File: rtl/serial_comparator.sv
`default_nettype none
// ============================================================================
// Module      : serial_comparator
// Description : Multi-cycle WIDTH-bit magnitude comparator. Compares DIGIT
//               bits per cycle, MSB digit first, and stops on the first
//               differing digit. Unsigned or two's-complement compare,
//               valid/ready handshake on both sides.
// Ports       : clk, rst            - clock, async active-high reset
//               in_valid / in_ready - operand handshake (A, B, signed_mode)
//               out_valid/out_ready - result handshake
//               equal/greater/lesser- result flags, held until next result
//               busy                - compare in progress
// Revision    : 1.0 - initial release
// ============================================================================
module serial_comparator
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             equal,
    output logic             greater,
    output logic             lesser,
    output logic             busy
);

    localparam int              NDIG   = num_digits(WIDTH, DIGIT);
    localparam int              IDXW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] c_LAST = IDXW'(NDIG - 1);

    cmp_state_t       r_state;
    cmp_state_t       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [IDXW-1:0]  r_idx;
    logic             r_equal;
    logic             r_greater;
    logic             r_lesser;

    logic             w_accept;
    logic             w_last;
    logic             w_finish;
    logic             w_gt;
    logic             w_lt;
    logic             w_eq;

    // The operand registers shift left one digit per RUN cycle, so the digit
    // under test (NDIG-1-idx of the latched operands) always sits at the top.
    // Only the first digit carries the sign bit.
    digit_compare #(
        .DIGIT (DIGIT)
    ) u_digit_compare (
        .a         (r_a[WIDTH-1 -: DIGIT]),
        .b         (r_b[WIDTH-1 -: DIGIT]),
        .sign_flip (r_signed && (r_idx == '0)),
        .gt        (w_gt),
        .lt        (w_lt),
        .eq        (w_eq)
    );

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_idx == c_LAST);
    assign w_finish = (r_state == RUN) && (!w_eq || w_last);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next = RUN;
            RUN:     if (w_finish)  w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    // Operand shift registers, digit index and result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_idx     <= '0;
            r_equal   <= 1'b0;
            r_greater <= 1'b0;
            r_lesser  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a      <= A;
                r_b      <= B;
                r_signed <= signed_mode;
                r_idx    <= '0;
            end else if ((r_state == RUN) && !w_finish) begin
                r_a   <= r_a << DIGIT;
                r_b   <= r_b << DIGIT;
                r_idx <= r_idx + 1'b1;
            end

            if (w_finish) begin
                if (w_eq) begin
                    {r_equal, r_greater, r_lesser} <= c_EQ;
                end else if (w_gt) begin
                    {r_equal, r_greater, r_lesser} <= c_GT;
                end else begin
                    {r_equal, r_greater, r_lesser} <= c_LT;
                end
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign equal     = r_equal;
    assign greater   = r_greater;
    assign lesser    = r_lesser;

endmodule : serial_comparator
`default_nettype wire
